// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 codes, FSM state encoding, error bit indices and the request bundle.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERR  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_EXT  = 3'd3;
    localparam logic [2:0] ST_MRG  = 3'd4;
    localparam logic [2:0] ST_WR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_ERR  = ST_ERR,
        S_RD   = ST_RD,
        S_EXT  = ST_EXT,
        S_MRG  = ST_MRG,
        S_WR   = ST_WR
    } state_t;

    localparam int ERR_MIS = 0;
    localparam int ERR_ILL = 1;
    localparam int ERR_OOR = 2;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load extraction with sign/zero extension and sub-word store merge.
// Ports: word (memory word), wdata (store lanes), funct3, lane -> ldata, mdata.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        ldata = '0;
        unique case (funct3)
            F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ldata = {24'h0, byte_sel};
            F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ldata = {16'h0, half_sel};
            F3_W:    ldata = word;
            default: ldata = '0;
        endcase
    end

    always_comb begin
        mdata = word;
        unique case (funct3)
            F3_B: mdata[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) mdata[31:16] = wdata;
                else         mdata[15:0]  = wdata;
            end
            default: mdata = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-wide synchronous data memory.
// Ports: req_* from execute, resp_* back to core, dmem_* to data memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_err,
    output logic        dmem_load,
    output logic        dmem_store,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

    state_t     state, state_d;
    lsu_req_t   req_q;
    logic       accept;
    logic [2:0] err_d;
    logic       mis, ill;
    logic       rv_d;
    logic [31:0] rdata_d;
    logic [2:0]  rerr_d;
    logic [31:0] ldata, mdata;

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign dmem_load  = (state == S_RD);
    assign dmem_store = (state == S_WR);
    assign dmem_addr  = {req_q.addr[31:2], 2'b00};
    assign dmem_wdata = req_q.wdata;

    lsu_align u_align (
        .word   (dmem_rdata),
        .wdata  (req_q.wdata[15:0]),
        .funct3 (req_q.funct3),
        .lane   (req_q.addr[1:0]),
        .ldata  (ldata),
        .mdata  (mdata)
    );

    // Illegal funct3 masks the other two causes.
    always_comb begin
        mis = 1'b0;
        ill = 1'b0;
        unique case (req_funct3)
            F3_B:    mis = 1'b0;
            F3_H:    mis = req_addr[0];
            F3_W:    mis = |req_addr[1:0];
            F3_BU:   ill = req_we;
            F3_HU: begin
                ill = req_we;
                mis = req_addr[0];
            end
            default: ill = 1'b1;
        endcase
        err_d = '0;
        if (ill) begin
            err_d[ERR_ILL] = 1'b1;
        end else begin
            err_d[ERR_MIS] = mis;
            err_d[ERR_OOR] = (req_addr >= DMEM_LIMIT);
        end
    end

    always_comb begin
        state_d = state;
        rv_d    = 1'b0;
        rdata_d = '0;
        rerr_d  = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (|err_d) begin
                        // Fault response goes out in the ERR cycle itself.
                        state_d = S_ERR;
                        rv_d    = 1'b1;
                        rerr_d  = err_d;
                    end else if (!req_we) begin
                        state_d = S_RD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_ERR: state_d = S_IDLE;
            S_RD:  state_d = req_q.we ? S_MRG : S_EXT;
            S_EXT: begin
                state_d = S_IDLE;
                rv_d    = 1'b1;
                rdata_d = ldata;
            end
            S_MRG: state_d = S_WR;
            S_WR: begin
                state_d = S_IDLE;
                rv_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_q      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= '0;
        end else begin
            state      <= state_d;
            resp_valid <= rv_d;
            resp_rdata <= rdata_d;
            resp_err   <= rerr_d;
            if (accept) begin
                req_q <= '{we: req_we, funct3: req_funct3,
                           addr: req_addr, wdata: req_wdata};
            end else if (state == S_MRG) begin
                req_q.wdata <= mdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word-wide synchronous memory model.
// Each task drives one scenario and checks hand-computed results.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_err;
    logic        dmem_load, dmem_store;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;

    logic [31:0] mem [0:1023];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DMEM_BYTES(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_load  (dmem_load),
        .dmem_store (dmem_store),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    always @(posedge clk) begin
        if (dmem_store) mem[dmem_addr[11:2]] <= dmem_wdata;
        dmem_rdata <= dmem_load ? mem[dmem_addr[11:2]] : 32'h0;
    end

    int          lat, nld, nst, st_k;
    logic [31:0] rd, st_d, st_a;
    logic [2:0]  er;

    task automatic run_req(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd
    );
        lat = -1; rd = 'x; er = 'x;
        nld = 0; nst = 0; st_k = -1;
        st_d = '0; st_a = '0;
        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (dmem_load) nld++;
            if (dmem_store) begin
                nst++; st_k = k; st_d = dmem_wdata; st_a = dmem_addr;
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++;
            $display("FAIL rst_ready got %b exp 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++;
            $display("FAIL rst_rv got %b exp 0", resp_valid); end
        tests++; if (resp_rdata !== 32'h0 || resp_err !== 3'b0) begin fails++;
            $display("FAIL rst_resp got %h/%b exp 0/0", resp_rdata, resp_err); end
        tests++; if (dmem_load !== 1'b0 || dmem_store !== 1'b0) begin fails++;
            $display("FAIL rst_strobe got %b%b exp 00", dmem_load, dmem_store); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw_sh();
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        tests++; if (lat !== 2) begin fails++;
            $display("FAIL sw_lat got %0d exp 2", lat); end
        tests++; if (st_k !== 1 || nst !== 1 || nld !== 0) begin fails++;
            $display("FAIL sw_strobe got k%0d st%0d ld%0d exp k1 st1 ld0", st_k, nst, nld); end
        tests++; if (st_d !== 32'hDEADBEEF || st_a !== 32'h10) begin fails++;
            $display("FAIL sw_data got %h@%h exp deadbeef@10", st_d, st_a); end
        tests++; if (rd !== 32'h0 || er !== 3'b0) begin fails++;
            $display("FAIL sw_resp got %h/%b exp 0/0", rd, er); end
        run_req(1'b1, 3'b001, 32'h12, 32'h0000CAFE);
        tests++; if (lat !== 4 || nld !== 1) begin fails++;
            $display("FAIL sh_lat got %0d ld%0d exp 4 ld1", lat, nld); end
        tests++; if (mem[4] !== 32'hCAFEBEEF) begin fails++;
            $display("FAIL sh_mem got %h exp cafebeef", mem[4]); end
    endtask

    task automatic test_loads();
        run_req(1'b1, 3'b010, 32'h40, 32'h8899AABB);
        run_req(1'b0, 3'b000, 32'h41, 32'h0);
        tests++; if (lat !== 3 || nld !== 1 || nst !== 0) begin fails++;
            $display("FAIL lb_lat got %0d ld%0d st%0d exp 3 1 0", lat, nld, nst); end
        tests++; if (rd !== 32'hFFFFFFAA || er !== 3'b0) begin fails++;
            $display("FAIL lb_data got %h/%b exp ffffffaa/0", rd, er); end
        run_req(1'b0, 3'b100, 32'h43, 32'h0);
        tests++; if (rd !== 32'h00000088 || lat !== 3) begin fails++;
            $display("FAIL lbu_data got %h lat%0d exp 00000088 3", rd, lat); end
        run_req(1'b0, 3'b101, 32'h42, 32'h0);
        tests++; if (rd !== 32'h00008899) begin fails++;
            $display("FAIL lhu_data got %h exp 00008899", rd); end
        run_req(1'b0, 3'b001, 32'h40, 32'h0);
        tests++; if (rd !== 32'hFFFFAABB) begin fails++;
            $display("FAIL lh_data got %h exp ffffaabb", rd); end
    endtask

    task automatic test_sub_store();
        run_req(1'b1, 3'b000, 32'h42, 32'h12345677);
        tests++; if (st_k !== 3 || nst !== 1 || nld !== 1) begin fails++;
            $display("FAIL sb_strobe got k%0d st%0d ld%0d exp k3 1 1", st_k, nst, nld); end
        tests++; if (st_d !== 32'h8877AABB || st_a !== 32'h40) begin fails++;
            $display("FAIL sb_data got %h@%h exp 8877aabb@40", st_d, st_a); end
        tests++; if (lat !== 4) begin fails++;
            $display("FAIL sb_lat got %0d exp 4", lat); end
        run_req(1'b0, 3'b010, 32'h40, 32'h0);
        tests++; if (rd !== 32'h8877AABB || lat !== 3) begin fails++;
            $display("FAIL sb_readback got %h lat%0d exp 8877aabb 3", rd, lat); end
    endtask

    task automatic test_errors();
        run_req(1'b1, 3'b010, 32'h0, 32'h01020304);
        run_req(1'b0, 3'b010, 32'h06, 32'h0);
        tests++; if (lat !== 1 || er !== 3'b001 || rd !== 32'h0) begin fails++;
            $display("FAIL err_mis got lat%0d %b %h exp 1 001 0", lat, er, rd); end
        tests++; if (nld !== 0 || nst !== 0) begin fails++;
            $display("FAIL err_mis_strobe got ld%0d st%0d exp 0 0", nld, nst); end
        run_req(1'b0, 3'b011, 32'h0, 32'h0);
        tests++; if (er !== 3'b010 || lat !== 1) begin fails++;
            $display("FAIL err_ill got %b lat%0d exp 010 1", er, lat); end
        run_req(1'b1, 3'b010, 32'd4096, 32'hFFFFFFFF);
        tests++; if (er !== 3'b100 || nst !== 0) begin fails++;
            $display("FAIL err_oor got %b st%0d exp 100 0", er, nst); end
        tests++; if (mem[0] !== 32'h01020304) begin fails++;
            $display("FAIL err_oor_mem got %h exp 01020304", mem[0]); end
        run_req(1'b1, 3'b001, 32'd4097, 32'h0);
        tests++; if (er !== 3'b101) begin fails++;
            $display("FAIL err_mis_oor got %b exp 101", er); end
        run_req(1'b1, 3'b100, 32'h3, 32'h0);
        tests++; if (er !== 3'b010) begin fails++;
            $display("FAIL err_ill_st got %b exp 010", er); end
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        logic [31:0] d1, d2;
        logic rdy1;
        run_req(1'b1, 3'b010, 32'h4, 32'hA5A55A5A);
        k1 = -1; k2 = -1; d1 = '0; d2 = '0; rdy1 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = '0;
        @(posedge clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (resp_valid && k1 < 0) begin
                k1 = k; d1 = resp_rdata; rdy1 = req_ready;
                req_addr = 32'h4;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end else if (resp_valid) begin
                k2 = k; d2 = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
        tests++; if (k1 !== 3 || rdy1 !== 1'b1) begin fails++;
            $display("FAIL b2b_first got k%0d rdy%b exp 3 1", k1, rdy1); end
        tests++; if (k2 !== 6) begin fails++;
            $display("FAIL b2b_second got k%0d exp 6", k2); end
        tests++; if (d1 !== 32'h01020304 || d2 !== 32'hA5A55A5A) begin fails++;
            $display("FAIL b2b_data got %h %h exp 01020304 a5a55a5a", d1, d2); end
    endtask

    task automatic test_reset_mrg();
        int nst_r, nrv_r;
        run_req(1'b1, 3'b010, 32'h50, 32'h11223344);
        nst_r = 0; nrv_r = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h51; req_wdata = 32'h000000EE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++;
            $display("FAIL mrg_rst got rdy%b rv%b exp 1 0", req_ready, resp_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (dmem_store) nst_r++;
            if (resp_valid) nrv_r++;
        end
        tests++; if (nst_r !== 0 || nrv_r !== 0) begin fails++;
            $display("FAIL mrg_rst_strobe got st%0d rv%0d exp 0 0", nst_r, nrv_r); end
        tests++; if (mem[20] !== 32'h11223344) begin fails++;
            $display("FAIL mrg_rst_mem got %h exp 11223344", mem[20]); end
    endtask

    initial begin
        test_reset();
        test_sw_sh();
        test_loads();
        test_sub_store();
        test_errors();
        test_back_to_back();
        test_reset_mrg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the data memory. It accepts one RV32I load or store per transaction from the execute stage.
- Converts byte and halfword accesses into the word-only, synchronous-read/synchronous-write protocol of the data memory. Sub-word stores use read-modify-write.
- Sign/zero-extends load results and reports misaligned, illegal-funct3 and out-of-range accesses without touching memory.

Parameters:
- DMEM_BYTES, 4096, size of data memory in bytes; byte addresses >= DMEM_BYTES raise an access fault.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit idle; a request is accepted when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_err  output  3  bit0 misaligned, bit1 illegal funct3, bit2 out of range.
- dmem_load  output  1  read strobe to data memory.
- dmem_store  output  1  write strobe to data memory.
- dmem_addr  output  32  always {addr_q[31:2],2'b00}.
- dmem_wdata  output  32  word to write.
- dmem_rdata  input  32  memory read data; valid the cycle after dmem_load, 0 otherwise.

Behaviour:
- Reset (async): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0; request registers cleared. dmem_load/dmem_store decode from state and drop immediately. An in-flight RMW is abandoned and memory is unchanged, since writes occur only in state WR.
- req_ready = (state==IDLE). On accept, latch we, funct3, addr, wdata and compute err.
- Misalignment rules: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte accesses are always aligned.
- Illegal funct3: loads 011/110/111; stores >= 011.
- Error priority: illegal funct3 takes priority; misaligned and range bits may both be set.
- States: IDLE, ERR, RD, EXT, MRG, WR. The accept cycle is T0.
- Any err bit: IDLE->ERR. At T1, resp_valid=1 with resp_err set and resp_rdata=0. No dmem strobe.
- Load: IDLE->RD (T1: dmem_load=1) -> EXT (T2: dmem_rdata extracted and registered) -> IDLE. resp_valid at T3.
- SW: IDLE->WR (T1: dmem_store=1, dmem_wdata=wdata_q) -> IDLE. resp_valid at T2.
- SB/SH: IDLE->RD (T1: dmem_load=1) -> MRG (T2: merge wdata lane into dmem_rdata, register into wdata_q) -> WR (T3: dmem_store=1) -> IDLE. resp_valid at T4.
- resp_valid is registered and asserted the cycle the state returns to IDLE. A new request may be accepted in that same cycle; back-to-back throughput equals the latency.
- Load extraction, lane = addr[1:0]:
  - LB: sign-extend byte[lane].
  - LBU: zero-extend byte[lane].
  - LH: sign-extend half[addr[1]].
  - LHU: zero-extend half[addr[1]].
  - LW: full word.
- Store merge: SB replaces byte[lane] with wdata[7:0]; SH replaces half[addr[1]] with wdata[15:0]; all other bytes are preserved.
- dmem_load and dmem_store are never asserted together and are 0 in IDLE, ERR, EXT and MRG.
- req_* inputs are ignored when req_ready=0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding localparams.
  - err bit indices ERR_MIS, ERR_ILL, ERR_OOR.
- One combinational sub-module, lsu_align: load extract (word, funct3, addr[1:0] -> data) and store merge (word, wdata, funct3, addr[1:0] -> merged word).

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB @0x41 -> resp at T3, rdata 0xFFFFFFAA, err 0. LBU @0x43 -> 0x00000088. LHU @0x42 -> 0x00008899. LH @0x40 -> 0xFFFFAABB.
- SB wdata 0x12345677 @0x42 on word 0x8899AABB -> dmem_store at T3 with wdata 0x8877AABB; resp_valid at T4. A subsequent LW @0x40 returns 0x8877AABB.
- SW 0xDEADBEEF @0x10 -> dmem_store only at T1, resp_valid at T2, no dmem_load. SH 0xCAFE @0x12 -> word becomes 0xCAFEBEEF.
- LW @0x06 -> resp_valid at T1, err=001, rdata 0, no strobes. Load funct3 011 -> err=010. SW @DMEM_BYTES -> err=100, memory untouched.
- Back-to-back: req_valid held with LW @0x0 then LW @0x4 -> second accepted in the resp_valid cycle of the first; responses arrive 3 cycles apart.
- Assert rst during MRG of an SB -> state IDLE, resp_valid=0, dmem_store never asserted. After reset, the target word is unchanged or zeroed by memory reset, never partially merged.
